// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous-write, registered-address RAM.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins ties.
//
// state | meaning
// IDLE  | waiting for a request; picks a winner and latches its command
// CMD   | RAM command on the bus, grant pulse to the winner
// RDATA | RAM read data returned, rvalid pulse to the winner
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;
  logic              pick;
  logic              winId;
  logic              winWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic [DATA_W-1:0] rdataHold;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic              lastWinner;
`endif

  // Tie-break only matters when both ports ask in the same IDLE cycle.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      pick = ~lastWinner;
`else
      pick = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    ram_we    = 1'b0;
    rdata     = rdataHold;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          nextState = CMD;
        end
      end
      CMD: begin
        gnt0      = ~winId;
        gnt1      = winId;
        ram_we    = winWe;
        nextState = winWe ? IDLE : RDATA;
      end
      RDATA: begin
        rvalid0   = ~winId;
        rvalid1   = winId;
        rdata     = ram_dout;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // RAM address/data come straight from the latched command so they hold between accesses.
  assign ram_addr = latAddr;
  assign ram_din  = latData;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      winId     <= 1'b0;
      winWe     <= 1'b0;
      latAddr   <= '0;
      latData   <= '0;
      rdataHold <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      lastWinner <= 1'b1;
`endif
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        winId   <= pick;
        winWe   <= pick ? we1 : we0;
        latAddr <= pick ? addr1 : addr0;
        latData <= pick ? wdata1 : wdata0;
      end
      if (state == RDATA) begin
        rdataHold <= ram_dout;
      end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (state == CMD) begin
        lastWinner <= winId;
      end
`endif
    end
  end

endmodule
